// File: rtl/dcache_resp_pkg.sv
// rtl/dcache_resp_pkg.sv - shared config: sizes, defaults, load FSM states, byte merge helper
package dcache_resp_pkg;

  localparam int MEM_WORDS_DEFAULT    = 4096;
  localparam int LOAD_LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D} inst_size_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} load_state_e;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    res = old_word;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_ports_if.sv
// rtl/dcache_ports_if.sv - store/load request and load response bundle between core and data cache
interface dcache_ports_if;
  import dcache_resp_pkg::*;

  logic [63:0] waddr;
  inst_size_t  wsize;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [63:0] load_a_addr;
  logic        load_a_valid;
  logic        load_a_ready;
  logic [63:0] load_d_data;
  logic        load_d_valid;

  modport responder (
    input  waddr, wsize, wdata, wmask, wvalid, load_a_addr, load_a_valid,
    output wready, load_a_ready, load_d_data, load_d_valid
  );

  modport requester (
    output waddr, wsize, wdata, wmask, wvalid, load_a_addr, load_a_valid,
    input  wready, load_a_ready, load_d_data, load_d_valid
  );

endinterface

// File: rtl/dcache_resp_mem.sv
// rtl/dcache_resp_mem.sv - 64-bit word array, byte-masked write port and combinational read-old port
module dcache_resp_mem #(
  parameter int MEM_WORDS = 4096,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wmask,
  input  logic [AW-1:0] ridx,
  output logic [63:0]   rdata
);

  logic [63:0] mem [MEM_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we && wmask[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dcache_resp.sv
// rtl/dcache_resp.sv - data-cache responder: every-cycle stores, one outstanding fixed-latency load
module dcache_resp
  import dcache_resp_pkg::*;
#(
  parameter int MEM_WORDS    = MEM_WORDS_DEFAULT,
  parameter int LOAD_LATENCY = LOAD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic stall_i,
  dcache_ports_if.responder dcache_ports_io
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LATENCY - 1);

  load_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ld_idx_q, acc_idx, w_idx, rd_idx;
  logic [63:0]   rd_word, fwd_word;
  logic          st_acc, ld_acc, rd_now;
  logic          unused_addr_bits;

  assign dcache_ports_io.wready       = rstn & ~stall_i;
  assign dcache_ports_io.load_a_ready = rstn & ~stall_i & (state_q != WAIT);
  assign dcache_ports_io.load_d_valid = (state_q == RESP);

  assign st_acc  = dcache_ports_io.wvalid & dcache_ports_io.wready;
  assign ld_acc  = dcache_ports_io.load_a_valid & dcache_ports_io.load_a_ready;
  assign acc_idx = dcache_ports_io.load_a_addr[AW+2:3];
  assign w_idx   = dcache_ports_io.waddr[AW+2:3];

  assign unused_addr_bits = ^{dcache_ports_io.wsize,
                              dcache_ports_io.waddr[63:AW+3], dcache_ports_io.waddr[2:0],
                              dcache_ports_io.load_a_addr[63:AW+3], dcache_ports_io.load_a_addr[2:0]};

  // The read cycle is the accept cycle itself at latency 1, else the last WAIT cycle.
  assign rd_now = (LOAD_LATENCY == 1) ? ld_acc : ((state_q == WAIT) && (cnt_q == CW'(1)));
  assign rd_idx = (LOAD_LATENCY == 1) ? acc_idx : ld_idx_q;

  // A same-cycle store to the word being read is folded in so the response sees it.
  assign fwd_word = (st_acc && (w_idx == rd_idx))
                  ? byte_merge(rd_word, dcache_ports_io.wdata, dcache_ports_io.wmask)
                  : rd_word;

  dcache_resp_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .we    (st_acc),
    .widx  (w_idx),
    .wdata (dcache_ports_io.wdata),
    .wmask (dcache_ports_io.wmask),
    .ridx  (rd_idx),
    .rdata (rd_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (ld_acc) begin
          if (LOAD_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q                     <= IDLE;
      cnt_q                       <= '0;
      ld_idx_q                    <= '0;
      dcache_ports_io.load_d_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld_acc) ld_idx_q <= acc_idx;
      if (rd_now) dcache_ports_io.load_d_data <= fwd_word;
    end
  end

endmodule

// File: tb/tb_dcache_resp.sv
// tb/tb_dcache_resp.sv - directed and random stimulus against a word-array model with due-cycle tracking
module tb_dcache_resp;
  import dcache_resp_pkg::*;

  localparam int MW  = 4096;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstn;
  logic stall_i;

  dcache_ports_if dp ();

  dcache_resp #(.MEM_WORDS(MW), .LOAD_LATENCY(LAT)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .stall_i         (stall_i),
    .dcache_ports_io (dp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [63:0] mm [int];
  bit          pending = 0;
  int          due     = 0;
  int          ld_word = 0;
  logic [63:0] exp_data = 64'h0;

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) % MW);
  endfunction

  function automatic logic [63:0] rand_addr(input int w);
    logic [63:0] a;
    a = {$urandom, $urandom};
    a = (a & ~(64'(MW - 1) << 3)) | (64'(w) << 3);
    return a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    bit exp_valid, exp_lready, exp_wready;
    logic [63:0] w;
    #1;
    if (!rstn) begin
      pending  = 0;
      exp_data = 64'h0;
    end
    exp_valid  = pending && (cyc == due);
    exp_wready = rstn && !stall_i;
    exp_lready = rstn && !stall_i && !(pending && cyc != due);
    chk("wready",       64'(dp.wready),       64'(exp_wready));
    chk("load_a_ready", 64'(dp.load_a_ready), 64'(exp_lready));
    chk("load_d_valid", 64'(dp.load_d_valid), 64'(exp_valid));
    chk("load_d_data",  dp.load_d_data,       exp_data);
    if (pending && cyc == due) pending = 0;
    if (exp_wready && dp.wvalid) begin
      w = mm.exists(word_of(dp.waddr)) ? mm[word_of(dp.waddr)] : 64'hx;
      for (int i = 0; i < 8; i++)
        if (dp.wmask[i]) w[8*i +: 8] = dp.wdata[8*i +: 8];
      mm[word_of(dp.waddr)] = w;
    end
    if (exp_lready && dp.load_a_valid) begin
      pending = 1;
      due     = cyc + LAT;
      ld_word = word_of(dp.load_a_addr);
    end
    if (pending && cyc == due - 1) exp_data = mm[ld_word];
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit st, input bit wv, input logic [63:0] wa, input logic [63:0] wd,
                       input logic [7:0] wm, input bit lv, input logic [63:0] la);
    stall_i         = st;
    dp.wvalid       = wv;
    dp.waddr        = wa;
    dp.wdata        = wd;
    dp.wmask        = wm;
    dp.load_a_valid = lv;
    dp.load_a_addr  = la;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 64'h0, 64'h0, 8'h0, 0, 64'h0);
  endtask

  initial begin
    rstn            = 1'b0;
    stall_i         = 1'b0;
    dp.wsize        = SIZE_D;
    dp.wvalid       = 1'b1;
    dp.waddr        = 64'h0;
    dp.wdata        = 64'h0;
    dp.wmask        = 8'hFF;
    dp.load_a_valid = 1'b1;
    dp.load_a_addr  = 64'h0;
    @(negedge clk);
    tick();
    tick();
    rstn = 1'b1;

    for (int w = 0; w < 16; w++) drive(0, 1, 64'(w) << 3, {$urandom, $urandom}, 8'hFF, 0, 64'h0);

    // Partial store then load of the same word
    drive(0, 1, 64'h10, 64'h00000000_0000AB00, 8'h02, 0, 64'h0);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h10);
    idle(3);

    // Back-to-back loads; WAIT cycles are refused
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h0);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h8);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h8);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h10);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h10);
    idle(3);

    // Store in the read cycle of a load to the same word
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h20);
    drive(0, 1, 64'h20, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 64'h0);
    idle(3);

    // Stall during WAIT: response on time, stores dropped
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h18);
    drive(1, 1, 64'h18, 64'h1111_2222_3333_4444, 8'hFF, 1, 64'h18);
    drive(1, 1, 64'h18, 64'h5555_6666_7777_8888, 8'hFF, 1, 64'h18);
    drive(1, 1, 64'h18, 64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1, 64'h18);
    idle(1);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h18);
    idle(3);

    // Reset during WAIT drops the response; array survives
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h28);
    rstn = 1'b0;
    drive(0, 1, 64'h28, 64'h0, 8'hFF, 1, 64'h28);
    drive(0, 1, 64'h28, 64'h0, 8'hFF, 1, 64'h28);
    rstn = 1'b1;
    idle(3);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h28);
    idle(3);

    // Aliasing of upper address bits
    drive(0, 1, 64'h8 + 64'(8 * MW), 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'h0);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h8);
    idle(2);
    drive(0, 1, 64'h8, 64'hFEDC_BA98_7654_3210, 8'hF0, 0, 64'h0);
    drive(0, 0, 64'h0, 64'h0, 8'h0, 1, 64'h8 + 64'(8 * MW));
    idle(3);

    for (int n = 0; n < 1500; n++) begin
      drive(($urandom % 6) == 0, $urandom % 2, rand_addr($urandom_range(0, 15)),
            {$urandom, $urandom}, 8'($urandom), ($urandom % 3) != 0,
            rand_addr($urandom_range(0, 15)));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
